obf_key_loader: RTL

- Upstream key-delivery stage for the logic-locked c432 netlists. It serially receives the obfuscation key from the secure key store over a valid/ready bit stream.
- It assembles the key in a shadow register and atomically drives the core's key inputs s_0..s_(KEY_W-1) via key_o.
- The core sees a constant all-zero key until a complete, checked key has been committed.

---
 rtl/obf_key_pkg.sv | 23 ++
 rtl/obf_key_shreg.sv | 32 +++
 rtl/obf_key_loader.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/obf_key_pkg.sv
// Shared types and helpers for the c432 obfuscation key loader.
// Holds the loader state encoding, default key width and parity helper.
package obf_key_pkg;

  localparam int KEY_W_DEFAULT = 12;
  localparam int KEY_W_MAX     = 64;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PAR,
    COMMIT
  } state_t;

  // Zero-extension does not change parity, so any key up to
  // KEY_W_MAX bits can be passed in widened.
  function automatic logic even_parity(
    input logic [KEY_W_MAX-1:0] v
  );
    return ^v;
  endfunction

endpackage

// File: rtl/obf_key_shreg.sv
// Indexed shadow register: synchronous clear, bit-index write.
// Ports: clk, rst_n, clr, we, idx, din -> q (shadow contents).
module obf_key_shreg
  import obf_key_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEFAULT,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [CNT_W-1:0] idx,
  input  logic             din,
  output logic [KEY_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else begin
      for (int i = 0; i < KEY_W; i++) begin
        if (we && idx == CNT_W'(i)) begin
          q[i] <= din;
        end
      end
    end
  end

endmodule

// File: rtl/obf_key_loader.sv
// Serial key loader for logic-locked c432: shifts key bits in LSB first,
// optionally checks even parity (OBF_KEY_PARITY_EN), then commits
// atomically to key_o. Ports: clk, rst_n, load_req, sdi, sdi_valid,
// sdi_ready, clear, key_o, key_ok, busy, err.
module obf_key_loader
  import obf_key_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEFAULT,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_req,
  input  logic             sdi,
  input  logic             sdi_valid,
  output logic             sdi_ready,
  input  logic             clear,
  output logic [KEY_W-1:0] key_o,
  output logic             key_ok,
  output logic             busy,
  output logic             err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(KEY_W - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [KEY_W-1:0] shadow;
  logic             sh_clr;
  logic             sh_we;
  logic             commit;

`ifdef OBF_KEY_PARITY_EN
  logic err_q;
  logic err_set;
  logic err_clr;
  logic par_ok;

  assign par_ok = (sdi == even_parity(KEY_W_MAX'(shadow)));
  assign err    = err_q;
`else
  assign err = 1'b0;
`endif

  assign sdi_ready = (state_q == SHIFT) || (state_q == PAR);
  assign busy      = (state_q != IDLE);

  obf_key_shreg #(
    .KEY_W (KEY_W),
    .CNT_W (CNT_W)
  ) u_shreg (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sh_clr),
    .we    (sh_we),
    .idx   (cnt_q),
    .din   (sdi),
    .q     (shadow)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_clr  = 1'b0;
    sh_we   = 1'b0;
    commit  = 1'b0;
`ifdef OBF_KEY_PARITY_EN
    err_set = 1'b0;
    err_clr = 1'b0;
`endif
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      sh_clr  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_req) begin
            state_d = SHIFT;
            cnt_d   = '0;
            sh_clr  = 1'b1;
`ifdef OBF_KEY_PARITY_EN
            err_clr = 1'b1;
`endif
          end
        end
        SHIFT: begin
          if (sdi_valid) begin
            sh_we = 1'b1;
            if (cnt_q == LAST) begin
              cnt_d = '0;
`ifdef OBF_KEY_PARITY_EN
              state_d = PAR;
`else
              state_d = COMMIT;
`endif
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        PAR: begin
`ifdef OBF_KEY_PARITY_EN
          if (sdi_valid) begin
            if (par_ok) begin
              state_d = COMMIT;
            end else begin
              state_d = IDLE;
              sh_clr  = 1'b1;
              err_set = 1'b1;
            end
          end
`else
          state_d = IDLE;
`endif
        end
        COMMIT: begin
          commit  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // key_o comes straight from these flops; the old key keeps
  // driving the core until a full, checked key commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_o  <= '0;
      key_ok <= 1'b0;
    end else if (clear) begin
      key_o  <= '0;
      key_ok <= 1'b0;
    end else if (commit) begin
      key_o  <= shadow;
      key_ok <= 1'b1;
    end
  end

`ifdef OBF_KEY_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end
`endif

endmodule
